// File: rtl/reg_ckpt_ctrl.sv
// Branch checkpoint buffer: snapshots the register file on speculative branches, retires in order,
// and drives the register file's restore/done/ack handshake on a mispredict while stalling fetch.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module reg_ckpt_ctrl #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               take_ckpt,
  input  logic [31:0][DATA_WIDTH-1:0]        regs_in,
  output logic                               ckpt_ready,
  output logic [$clog2(DEPTH)-1:0]           ckpt_id,
  input  logic                               resolve_valid,
  input  logic [$clog2(DEPTH)-1:0]           resolve_id,
  input  logic                               resolve_mispredict,
  output logic                               recover_snapshot,
  output logic [31:0][DATA_WIDTH-1:0]        regs_snapshot,
  input  logic                               done,
  output logic                               recovery_done_ack,
  output logic                               stall,
  output logic                               recovery_complete
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  typedef enum logic [1:0] {IDLE, RESTORE, ACK} state_t;

  state_t                     state, state_nxt;
  logic [IW-1:0]              head, tail, rec_id;
  logic [CW-1:0]              count;
  logic [DEPTH-1:0]           slot_vld, slot_res, kill;
  logic [31:0][DATA_WIDTH-1:0] slot_dat [DEPTH];

  logic          idle, mis_acc, res_ok, take_acc, retire;
  logic [IW-1:0] rec_off;

  assign idle     = (state == IDLE);
  assign mis_acc  = idle && resolve_valid && resolve_mispredict && slot_vld[resolve_id];
  assign res_ok   = idle && resolve_valid && !resolve_mispredict && slot_vld[resolve_id];
  // A take racing an accepted mispredict is younger than the bad branch, so it is dropped.
  assign take_acc = take_ckpt && ckpt_ready && !mis_acc;
  assign retire   = slot_vld[head] && slot_res[head] && !mis_acc;
  assign rec_off  = resolve_id - head;

  // Slots at or beyond the mispredicted one, in program order from head, are flushed.
  always_comb begin
    kill = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((IW'(i) - head) >= rec_off) kill[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      head     <= '0;
      tail     <= '0;
      rec_id   <= '0;
      count    <= '0;
      slot_vld <= '0;
      slot_res <= '0;
    end else begin
      state <= state_nxt;
      if (mis_acc) begin
        rec_id   <= resolve_id;
        tail     <= resolve_id;
        count    <= {1'b0, rec_off};
        slot_vld <= slot_vld & ~kill;
        slot_res <= slot_res & ~kill;
      end else begin
        if (take_acc) begin
          slot_vld[tail] <= 1'b1;
          slot_res[tail] <= 1'b0;
          tail           <= tail + 1'b1;
        end
        if (res_ok) slot_res[resolve_id] <= 1'b1;
        if (retire) begin
          slot_vld[head] <= 1'b0;
          slot_res[head] <= 1'b0;
          head           <= head + 1'b1;
        end
        case ({take_acc, retire})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (take_acc) slot_dat[tail] <= regs_in;
  end

  always_comb begin
    state_nxt         = state;
    recover_snapshot  = 1'b0;
    recovery_done_ack = 1'b0;
    recovery_complete = 1'b0;
    case (state)
      IDLE: begin
        if (mis_acc) state_nxt = RESTORE;
      end
      RESTORE: begin
        recover_snapshot = 1'b1;
        if (done) state_nxt = ACK;
      end
      ACK: begin
        recovery_done_ack = 1'b1;
        if (!done) begin
          state_nxt         = IDLE;
          recovery_complete = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign stall         = !idle;
  assign ckpt_ready    = !rst && idle && (count < CW'(DEPTH));
  assign ckpt_id       = tail;
  assign regs_snapshot = slot_dat[rec_id];

endmodule

// File: tb/tb_reg_ckpt_ctrl.sv
// Directed bench for reg_ckpt_ctrl: fill/wrap, in-order retirement, recovery handshake,
// dropped takes, invalid-slot mispredict, head mispredict and reset mid-recovery.
module tb_reg_ckpt_ctrl;

  logic              clk;
  logic              rst;
  logic              take_ckpt;
  logic [31:0][31:0] regs_in;
  logic              ckpt_ready;
  logic [1:0]        ckpt_id;
  logic              resolve_valid;
  logic [1:0]        resolve_id;
  logic              resolve_mispredict;
  logic              recover_snapshot;
  logic [31:0][31:0] regs_snapshot;
  logic              done;
  logic              recovery_done_ack;
  logic              stall;
  logic              recovery_complete;

  int n_assert = 0;
  int n_fail   = 0;

  reg_ckpt_ctrl #(.DEPTH(4), .DATA_WIDTH(32)) dut (
    .clk                (clk),
    .rst                (rst),
    .take_ckpt          (take_ckpt),
    .regs_in            (regs_in),
    .ckpt_ready         (ckpt_ready),
    .ckpt_id            (ckpt_id),
    .resolve_valid      (resolve_valid),
    .resolve_id         (resolve_id),
    .resolve_mispredict (resolve_mispredict),
    .recover_snapshot   (recover_snapshot),
    .regs_snapshot      (regs_snapshot),
    .done               (done),
    .recovery_done_ack  (recovery_done_ack),
    .stall              (stall),
    .recovery_complete  (recovery_complete)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_regs(input int v);
    regs_in    = '0;
    regs_in[0] = 32'hdead_0000 + v;
    regs_in[1] = v;
    regs_in[31] = v * 16;
  endtask

  initial begin
    rst = 1'b1; take_ckpt = 1'b0; resolve_valid = 1'b0; resolve_id = '0;
    resolve_mispredict = 1'b0; done = 1'b0; set_regs(0);
    #12;
    chk("rst_ready", ckpt_ready, 0);
    chk("rst_stall", stall, 0);
    chk("rst_recover", recover_snapshot, 0);
    chk("rst_ack", recovery_done_ack, 0);
    chk("rst_complete", recovery_complete, 0);
    chk("rst_id", ckpt_id, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", ckpt_ready, 1);

    // Fill all four slots, r1 = 1..4
    tick();
    for (int k = 0; k < 4; k++) begin
      take_ckpt = 1'b1; set_regs(k + 1);
      #1;
      chk("fill_id", ckpt_id, k);
      chk("fill_ready", ckpt_ready, 1);
      tick();
    end
    set_regs(99);
    #1;
    chk("full_ready", ckpt_ready, 0);
    chk("full_count", dut.count, 4);
    tick();
    chk("fifth_count", dut.count, 4);
    chk("fifth_tail_wrap", ckpt_id, 0);
    take_ckpt = 1'b0;

    // Out-of-order correct resolves: 1 then 0
    resolve_valid = 1'b1; resolve_mispredict = 1'b0; resolve_id = 2'd1;
    tick();
    chk("res1_count", dut.count, 4);
    resolve_id = 2'd0;
    tick();
    chk("res0_count", dut.count, 4);
    chk("res0_ready", ckpt_ready, 0);
    resolve_valid = 1'b0;
    tick();
    chk("retire0_count", dut.count, 3);
    chk("retire0_ready", ckpt_ready, 1);
    tick();
    chk("retire1_count", dut.count, 2);

    // Wrap: next take lands in slot 0 (r1=5)
    take_ckpt = 1'b1; set_regs(5);
    #1;
    chk("wrap_id", ckpt_id, 0);
    tick();
    chk("wrap_count", dut.count, 3);
    chk("wrap_tail", ckpt_id, 1);

    // Mispredict on slot 3 (order 2,3,0) with a simultaneous take
    set_regs(77);
    resolve_valid = 1'b1; resolve_mispredict = 1'b1; resolve_id = 2'd3;
    #1;
    chk("e0_pre_stall", stall, 0);
    tick();
    // Hold a take and a correct resolve on slot 2 across the whole stall
    resolve_mispredict = 1'b0; resolve_id = 2'd2;
    chk("e0_stall", stall, 1);
    chk("e0_recover", recover_snapshot, 1);
    chk("e0_snapshot_r1", regs_snapshot[1], 4);
    chk("e0_ready", ckpt_ready, 0);
    chk("e0_count", dut.count, 1);
    chk("e0_tail", ckpt_id, 3);
    tick();
    done = 1'b1;
    #1;
    chk("e1_recover", recover_snapshot, 1);
    chk("e1_snapshot_r31", regs_snapshot[31], 64);
    tick();
    chk("e2_ack", recovery_done_ack, 1);
    chk("e2_recover", recover_snapshot, 0);
    chk("e2_stall", stall, 1);
    chk("e2_complete", recovery_complete, 0);
    tick();
    done = 1'b0; take_ckpt = 1'b0; resolve_valid = 1'b0;
    #1;
    chk("e3_complete", recovery_complete, 1);
    chk("e3_stall", stall, 1);
    tick();
    chk("e4_stall", stall, 0);
    chk("e4_complete", recovery_complete, 0);
    chk("e4_ack", recovery_done_ack, 0);
    chk("e4_count", dut.count, 1);
    chk("e4_tail", ckpt_id, 3);
    chk("stall_resolve_ignored", dut.slot_res[2], 0);

    // Mispredict on a flushed slot is ignored
    resolve_valid = 1'b1; resolve_mispredict = 1'b1; resolve_id = 2'd0;
    tick();
    resolve_valid = 1'b0; resolve_mispredict = 1'b0;
    chk("inv_stall", stall, 0);
    chk("inv_recover", recover_snapshot, 0);
    chk("inv_count", dut.count, 1);

    // Take into slot 3 (r1=8), then mispredict on head slot 2
    take_ckpt = 1'b1; set_regs(8);
    tick();
    take_ckpt = 1'b0;
    chk("take8_count", dut.count, 2);
    resolve_valid = 1'b1; resolve_mispredict = 1'b1; resolve_id = 2'd2;
    tick();
    resolve_valid = 1'b0; resolve_mispredict = 1'b0;
    chk("head_recover", recover_snapshot, 1);
    chk("head_snapshot_r1", regs_snapshot[1], 3);
    chk("head_count", dut.count, 0);
    chk("head_tail", ckpt_id, 2);

    // Reset in RESTORE with the register file's done still high
    done = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_recover", recover_snapshot, 0);
    chk("mid_rst_ack", recovery_done_ack, 0);
    chk("mid_rst_ready", ckpt_ready, 0);
    chk("mid_rst_count", dut.count, 0);
    chk("mid_rst_tail", ckpt_id, 0);
    #1;
    rst = 1'b0;
    tick();
    chk("post_rst_done_ignored", stall, 0);
    take_ckpt = 1'b1; set_regs(9);
    #1;
    chk("post_rst_take_ready", ckpt_ready, 1);
    chk("post_rst_take_id", ckpt_id, 0);
    tick();
    take_ckpt = 1'b0; done = 1'b0;
    chk("post_rst_take_count", dut.count, 1);
    chk("post_rst_take_tail", ckpt_id, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
